cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Writeback-stage arbiter sitting on the consumer side of every execute-stage functional unit's valid/yumi result handshake. Each cycle it selects at most one functional unit holding a completed result, asserts that unit's yumi, and captures the result, ROB tag and branch outcome into a one-entry broadcast register. That register drives the common data bus (CDB) toward the ROB and reservation stations. Selection is round-robin so that no unit starves.

## Interface
- NUM_FU, 4, number of functional-unit result ports (2..8)
- XLEN, 32, result width
- ROB_W, 3, ROB tag width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- flush  input  1  pipeline flush; discards the broadcast register, no grant this cycle
- fu_valid  input  NUM_FU  per-unit result valid (unit's valid_out)
- fu_result  input  NUM_FU*XLEN  per-unit result, unit i at bits [i*XLEN +: XLEN]
- fu_rob  input  NUM_FU*ROB_W  per-unit ROB tag, unit i at [i*ROB_W +: ROB_W]
- fu_b_taken  input  NUM_FU  per-unit branch-taken flag
- fu_yumi  output  NUM_FU  one-hot-or-zero grant/consume to unit i (unit's yumi_in)
- cdb_ready  input  1  downstream (ROB) accepts the current broadcast this cycle
- cdb_valid  output  1  broadcast register holds a result
- cdb_result  output  XLEN  broadcast result
- cdb_rob  output  ROB_W  broadcast ROB tag
- cdb_b_taken  output  1  broadcast branch-taken flag

## Operation
- State: broadcast register (valid, result, rob, b_taken) and round-robin pointer rr_ptr (clog2(NUM_FU) bits).
- can_load = ~cdb_valid | cdb_ready. Grant is allowed only when can_load & ~flush & reset high.
- Grant selection is combinational. Search fu_valid starting at index rr_ptr, ascending with wrap modulo NUM_FU. The first set bit is the winner.
- fu_yumi[winner] = 1 when the grant is allowed and a winner exists. Otherwise fu_yumi = 0. Never more than one bit is set.
- On a grant edge:
  - The register loads fu_result, fu_rob and fu_b_taken of the winner, and cdb_valid <= 1.
  - rr_ptr <= (winner+1) mod NUM_FU.
- Without a grant:
  - If cdb_ready & cdb_valid, then cdb_valid <= 0 and the data fields hold.
  - If ~cdb_ready, all fields hold.
  - rr_ptr holds.
- flush: cdb_valid <= 0 and rr_ptr holds. fu_yumi is 0 in the flush cycle, so unit results stay pending.
- Reset (reset == 0): cdb_valid <= 0, cdb_result <= 0, cdb_rob <= 0, cdb_b_taken <= 0, rr_ptr <= 0. fu_yumi is forced to 0 combinationally. Reset has priority over flush and grant.
- The block does no arithmetic. Index wrap uses a modulo of NUM_FU, which must be correct for non-power-of-two NUM_FU.

## Timing
- Latency: a result granted in cycle T, with fu_yumi high during T, appears on cdb_valid/cdb_* in cycle T+1.
- A unit samples yumi at the T edge and clears its valid_out in T+1. The arbiter must not re-grant the same stale valid: a unit cannot be granted twice on consecutive edges unless its valid is reasserted.
- Throughput: 1 result/cycle while cdb_ready stays high. A back-to-back grant in T+1 is legal because can_load is true via cdb_ready.
- Backpressure: with cdb_valid=1 and cdb_ready=0, no yumi is issued and the outputs are stable. Units keep their results.
- All-FU-valid case: grants rotate 0,1,2,3,0,... regardless of which valids persist.
- fu_yumi depends combinationally on fu_valid, cdb_ready, flush and reset, with no register stage.

## Test plan
- Reset: hold reset=0 for 2 cycles with all fu_valid=1 -> fu_yumi=0 and cdb_valid=0 throughout. After release, the first grant goes to unit 0.
- Single unit: fu_valid=4'b0100, result 0x0000_00AB, rob 3'd5, b_taken=1, cdb_ready=1 -> fu_yumi=4'b0100 in T. In T+1, cdb_valid=1, cdb_result=0xAB, cdb_rob=5, cdb_b_taken=1.
- Fairness: all four valid continuously with cdb_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each unit is granted exactly twice.
- Backpressure: cdb_valid=1 with cdb_ready=0 for 3 cycles and units 1 and 3 valid -> fu_yumi=0 and outputs unchanged. When cdb_ready=1, grant goes to the rr_ptr-next valid unit the same cycle and the new result appears the next cycle.
- Flush: flush=1 while cdb_valid=1 and unit 2 valid -> fu_yumi=0, cdb_valid=0 next cycle, rr_ptr unchanged. Unit 2 is granted the cycle after flush deasserts.
- Wrap with gaps: rr_ptr=3 and fu_valid=4'b0010 -> unit 1 is granted and rr_ptr becomes 2.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin writeback arbiter; picks one completed FU result per cycle onto a one-entry CDB register.
// Latency: result granted (fu_yumi_o high) in cycle T is broadcast on cdb_*_o in cycle T+1.
// Backpressure: while the CDB register is full and cdb_ready_i is low, no yumi is issued and the outputs hold.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic [NUM_FU-1:0]       fu_valid_i,
    input  logic [NUM_FU*XLEN-1:0]  fu_result_i,
    input  logic [NUM_FU*ROB_W-1:0] fu_rob_i,
    input  logic [NUM_FU-1:0]       fu_b_taken_i,
    output logic [NUM_FU-1:0]       fu_yumi_o,
    input  logic                    cdb_ready_i,
    output logic                    cdb_valid_o,
    output logic [XLEN-1:0]         cdb_result_o,
    output logic [ROB_W-1:0]        cdb_rob_o,
    output logic                    cdb_b_taken_o
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    // One extra bit so rr_ptr + offset never overflows before the wrap subtract.
    localparam logic [PTR_W:0] NUM_FU_X = (PTR_W+1)'(NUM_FU);

    // Broadcast register and round-robin pointer.
    logic             cdb_valid_q,   cdb_valid_d;
    logic [XLEN-1:0]  cdb_result_q,  cdb_result_d;
    logic [ROB_W-1:0] cdb_rob_q,     cdb_rob_d;
    logic             cdb_b_taken_q, cdb_b_taken_d;
    logic [PTR_W-1:0] rr_ptr_q,      rr_ptr_d;

    // Arbitration results.
    logic             found;
    logic [PTR_W-1:0] win_idx;
    logic             grant_ok;
    logic             grant;
    logic [XLEN-1:0]  sel_result;
    logic [ROB_W-1:0] sel_rob;
    logic             sel_b_taken;

    // Search fu_valid_i from rr_ptr upward, wrapping modulo NUM_FU; first set bit wins.
    always_comb begin
        logic [PTR_W:0] idx_x;
        found   = 1'b0;
        win_idx = '0;
        idx_x   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx_x = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx_x >= NUM_FU_X) begin
                idx_x = idx_x - NUM_FU_X;
            end
            if (!found && fu_valid_i[PTR_W'(idx_x)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx_x);
            end
        end
    end

    // Grant qualification and one-hot yumi; the register can load when empty or being drained.
    always_comb begin
        grant_ok  = reset_i & ~flush_i & (~cdb_valid_q | cdb_ready_i);
        grant     = grant_ok & found;
        fu_yumi_o = '0;
        if (grant) begin
            fu_yumi_o[win_idx] = 1'b1;
        end
    end

    // Mux out the winning unit's result, tag and branch flag.
    always_comb begin
        sel_result  = '0;
        sel_rob     = '0;
        sel_b_taken = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_result  = fu_result_i[i*XLEN +: XLEN];
                sel_rob     = fu_rob_i[i*ROB_W +: ROB_W];
                sel_b_taken = fu_b_taken_i[i];
            end
        end
    end

    // Next-state: flush empties, grant loads and advances pointer, handshake alone empties.
    always_comb begin
        logic [PTR_W:0] nxt_x;
        cdb_valid_d   = cdb_valid_q;
        cdb_result_d  = cdb_result_q;
        cdb_rob_d     = cdb_rob_q;
        cdb_b_taken_d = cdb_b_taken_q;
        rr_ptr_d      = rr_ptr_q;
        nxt_x         = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (nxt_x == NUM_FU_X) begin
            nxt_x = '0;
        end
        if (flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (grant) begin
            cdb_valid_d   = 1'b1;
            cdb_result_d  = sel_result;
            cdb_rob_d     = sel_rob;
            cdb_b_taken_d = sel_b_taken;
            rr_ptr_d      = PTR_W'(nxt_x);
        end else if (cdb_ready_i && cdb_valid_q) begin
            cdb_valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cdb_valid_q   <= 1'b0;
            cdb_result_q  <= '0;
            cdb_rob_q     <= '0;
            cdb_b_taken_q <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            cdb_valid_q   <= cdb_valid_d;
            cdb_result_q  <= cdb_result_d;
            cdb_rob_q     <= cdb_rob_d;
            cdb_b_taken_q <= cdb_b_taken_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_result_o  = cdb_result_q;
    assign cdb_rob_o     = cdb_rob_q;
    assign cdb_b_taken_o = cdb_b_taken_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose: randomized + directed bench for cdb_arbiter with a queue scoreboard and FU behaviour model.
// Latency: expected broadcasts are queued at grant time and checked by the monitor one cycle later.
// Backpressure: cdb_ready_i is randomized; held broadcasts are re-checked every stalled cycle.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int RW = 3;

    typedef struct packed {
        logic [XL-1:0] res;
        logic [RW-1:0] rob;
        logic          bt;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            flush_i;
    logic [N-1:0]    fu_valid_i;
    logic [N*XL-1:0] fu_result_i;
    logic [N*RW-1:0] fu_rob_i;
    logic [N-1:0]    fu_b_taken_i;
    logic [N-1:0]    fu_yumi_o;
    logic            cdb_ready_i;
    logic            cdb_valid_o;
    logic [XL-1:0]   cdb_result_o;
    logic [RW-1:0]   cdb_rob_o;
    logic            cdb_b_taken_o;

    cdb_arbiter #(.NUM_FU(N), .XLEN(XL), .ROB_W(RW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .fu_valid_i   (fu_valid_i),
        .fu_result_i  (fu_result_i),
        .fu_rob_i     (fu_rob_i),
        .fu_b_taken_i (fu_b_taken_i),
        .fu_yumi_o    (fu_yumi_o),
        .cdb_ready_i  (cdb_ready_i),
        .cdb_valid_o  (cdb_valid_o),
        .cdb_result_o (cdb_result_o),
        .cdb_rob_o    (cdb_rob_o),
        .cdb_b_taken_o(cdb_b_taken_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    // Functional-unit model: each unit holds one pending result until consumed.
    logic          u_vld [N];
    logic [XL-1:0] u_res [N];
    logic [RW-1:0] u_rob [N];
    logic          u_bt  [N];

    // Reference model state: register occupancy, round-robin pointer, last grant.
    bit            mv;
    int            mptr;
    logic [N-1:0]  last_grant;
    exp_t          sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Round-robin rule: first valid unit found from index p upward, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_units();
        for (int i = 0; i < N; i++) begin
            fu_valid_i[i]              = u_vld[i];
            fu_result_i[i*XL +: XL]    = u_res[i];
            fu_rob_i[i*RW +: RW]       = u_rob[i];
            fu_b_taken_i[i]            = u_bt[i];
        end
    endtask

    // One clock cycle: retire consumed results, spawn new ones, drive, then predict and check yumi.
    task automatic step(input bit rdy, input bit fl, input bit rst, input int pnew,
                        input int ld, input logic [XL-1:0] lres, input logic [RW-1:0] lrob, input bit lbt);
        int           w;
        logic [N-1:0] vec;
        logic [N-1:0] exp_y;
        exp_t         e;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_grant[i]) u_vld[i] = 1'b0;
            if (!u_vld[i] && $urandom_range(99) < pnew) begin
                u_vld[i] = 1'b1;
                u_res[i] = $urandom;
                u_rob[i] = RW'($urandom);
                u_bt[i]  = 1'($urandom);
            end
        end
        if (ld >= 0) begin
            u_vld[ld] = 1'b1;
            u_res[ld] = lres;
            u_rob[ld] = lrob;
            u_bt[ld]  = lbt;
        end
        cdb_ready_i = rdy;
        flush_i     = fl;
        reset_i     = ~rst;
        drive_units();
        @(negedge clk_i);
        #1;
        for (int i = 0; i < N; i++) vec[i] = u_vld[i];
        w = -1;
        if (!rst && !fl && (!mv || rdy)) w = pick(vec, mptr);
        exp_y = '0;
        if (w >= 0) exp_y[w] = 1'b1;
        chk("fu_yumi", 64'(fu_yumi_o), 64'(exp_y));
        last_grant = exp_y;
        if (rst) begin
            mv   = 1'b0;
            mptr = 0;
        end else if (fl) begin
            mv = 1'b0;
        end else if (w >= 0) begin
            mv    = 1'b1;
            mptr  = (w + 1) % N;
            e.res = u_res[w];
            e.rob = u_rob[w];
            e.bt  = u_bt[w];
            sbq.push_back(e);
        end else if (rdy) begin
            mv = 1'b0;
        end
    endtask

    task automatic idle(input bit rdy, input int pnew);
        step(rdy, 1'b0, 1'b0, pnew, -1, '0, '0, 1'b0);
    endtask

    task automatic load(input bit rdy, input int ld, input logic [XL-1:0] r, input logic [RW-1:0] t, input bit b);
        step(rdy, 1'b0, 1'b0, 0, ld, r, t, b);
    endtask

    // Monitor: compare the broadcast register against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            chk("cdb_valid", 64'(cdb_valid_o), 64'(sbq.size() != 0));
            if (cdb_valid_o === 1'b1 && sbq.size() != 0) begin
                e = sbq[0];
                chk("cdb_result",  64'(cdb_result_o),  64'(e.res));
                chk("cdb_rob",     64'(cdb_rob_o),     64'(e.rob));
                chk("cdb_b_taken", 64'(cdb_b_taken_o), 64'(e.bt));
            end
            if (sbq.size() != 0 && (cdb_ready_i || flush_i || !reset_i)) begin
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int gcnt [N];
        for (int i = 0; i < N; i++) begin
            u_vld[i] = 1'b0; u_res[i] = '0; u_rob[i] = '0; u_bt[i] = 1'b0;
            gcnt[i]  = 0;
        end
        mv = 1'b0; mptr = 0; last_grant = '0;
        reset_i = 1'b0; flush_i = 1'b0; cdb_ready_i = 1'b1;
        drive_units();

        // Reset held two cycles with all units valid.
        step(1'b1, 1'b0, 1'b1, 100, -1, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 100, -1, '0, '0, 1'b0);
        chk("reset_result", 64'(cdb_result_o), 64'd0);
        chk("reset_rob",    64'(cdb_rob_o),    64'd0);
        chk("reset_bt",     64'(cdb_b_taken_o), 64'd0);

        // Fairness: all valid, ready high, 8 grants rotate starting from unit 0.
        for (int c = 0; c < 8; c++) begin
            idle(1'b1, 100);
            if (c == 0) chk("first_grant_after_reset", 64'(fu_yumi_o), 64'h1);
            for (int i = 0; i < N; i++) gcnt[i] += int'(fu_yumi_o[i]);
        end
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 64'(gcnt[i]), 64'd2);

        // Drain everything.
        for (int c = 0; c < 6; c++) idle(1'b1, 0);

        // Single unit: unit 2 with a known result.
        load(1'b1, 2, 32'h0000_00AB, 3'd5, 1'b1);
        chk("single_yumi", 64'(fu_yumi_o), 64'h4);
        idle(1'b1, 0);
        chk("single_result", 64'(cdb_result_o), 64'hAB);
        chk("single_rob",    64'(cdb_rob_o),    64'd5);

        // Wrap with gaps: pointer now 3, only unit 1 valid -> unit 1, pointer to 2.
        idle(1'b1, 0);
        load(1'b1, 1, 32'h1111_0001, 3'd1, 1'b0);
        chk("wrap_yumi", 64'(fu_yumi_o), 64'h2);
        step(1'b1, 1'b0, 1'b0, 0, 1, 32'h1111_0002, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 2, 32'h2222_0003, 3'd3, 1'b1);
        for (int c = 0; c < 4; c++) idle(1'b1, 0);

        // Backpressure: register full, ready low for 3 cycles with units 1 and 3 valid.
        load(1'b1, 0, 32'hCAFE_0000, 3'd0, 1'b0);
        load(1'b0, 1, 32'hCAFE_0001, 3'd6, 1'b1);
        load(1'b0, 3, 32'hCAFE_0003, 3'd7, 1'b0);
        idle(1'b0, 0);
        chk("bp_hold_yumi", 64'(fu_yumi_o), 64'h0);
        idle(1'b1, 0);
        idle(1'b1, 0);
        for (int c = 0; c < 4; c++) idle(1'b1, 0);

        // Flush while full with unit 2 pending; unit 2 granted after flush drops.
        load(1'b1, 0, 32'hF00D_0000, 3'd4, 1'b1);
        load(1'b0, 2, 32'hF00D_0002, 3'd2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, -1, '0, '0, 1'b0);
        chk("flush_yumi", 64'(fu_yumi_o), 64'h0);
        idle(1'b0, 0);
        chk("post_flush_yumi", 64'(fu_yumi_o), 64'h4);
        idle(1'b1, 0);

        // Randomized traffic with backpressure, flushes and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(99) < 70, $urandom_range(99) < 5, $urandom_range(199) == 0,
                 int'($urandom_range(80)), -1, '0, '0, 1'b0);
        end
        for (int c = 0; c < 6; c++) idle(1'b1, 0);

        @(posedge clk_i);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
